// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_WAIT = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  localparam int PC_B    = 0;
  localparam int IFID_B  = 1;
  localparam int IDEX_B  = 2;
  localparam int EXMEM_B = 3;
  localparam int MEMWB_B = 4;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/exception inputs and stall/flush/redirect outputs of the pipeline sequencer.
interface pipe_ctrl_if;
  logic        id_branch_stall_i;
  logic [4:0]  id_rs_i;
  logic [4:0]  id_rt_i;
  logic        ex_rmem_i;
  logic [4:0]  ex_waddr_i;
  logic        ex_div_i;
  logic        if_busy_i;
  logic        mem_busy_i;
  logic        exc_valid_i;
  logic        exc_is_eret_i;
  logic [31:0] epc_i;

  logic [4:0]  stall_o;
  logic [4:0]  flush_o;
  logic        new_pc_valid_o;
  logic [31:0] new_pc_o;
  logic        div_start_o;
  logic        div_done_o;
  logic        div_busy_o;

  modport master (
    output id_branch_stall_i, id_rs_i, id_rt_i, ex_rmem_i, ex_waddr_i, ex_div_i,
           if_busy_i, mem_busy_i, exc_valid_i, exc_is_eret_i, epc_i,
    input  stall_o, flush_o, new_pc_valid_o, new_pc_o, div_start_o, div_done_o, div_busy_o
  );

  modport slave (
    input  id_branch_stall_i, id_rs_i, id_rt_i, ex_rmem_i, ex_waddr_i, ex_div_i,
           if_busy_i, mem_busy_i, exc_valid_i, exc_is_eret_i, epc_i,
    output stall_o, flush_o, new_pc_valid_o, new_pc_o, div_start_o, div_done_o, div_busy_o
  );
endinterface

// File: rtl/pipe_ctrl_div_seq.sv
// Fixed-latency divider sequencer: start pulse, down-counter wait, result hold.
//   state    | meaning
//   RUN      | idle; a div in EX starts the divider (unless MEM busy or exception)
//   DIV_WAIT | divider running, counter counts down to terminal count 0
//   DIV_DONE | result valid; held until EX/MEM captures it
module div_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_ex_div,
  input  logic i_mem_busy,
  input  logic i_exc_valid,
  input  logic i_exmem_advance,
  output logic o_div_start,
  output logic o_div_busy,
  output logic o_div_done,
  output logic o_div_stall
);

  localparam int CW = $clog2(DIV_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_LAT - 1);
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_WAIT = DIV_WAIT;
  localparam logic [1:0] ST_DONE = DIV_DONE;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          w_start;

  assign w_start = (r_state == ST_RUN) & i_ex_div & ~i_exc_valid & ~i_mem_busy;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else if (i_exc_valid) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_start) begin
            r_state <= ST_WAIT;
            r_cnt   <= CNT_LOAD;
          end
        end
        // keeps counting through MEM stalls so latency stays fixed
        ST_WAIT: begin
          if (r_cnt == '0) r_state <= ST_DONE;
          else             r_cnt   <= r_cnt - CW'(1);
        end
        ST_DONE: begin
          if (i_exmem_advance) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign o_div_start = w_start;
  assign o_div_busy  = (r_state == ST_WAIT);
  assign o_div_done  = (r_state == ST_DONE);
  assign o_div_stall = ((r_state == ST_RUN) & i_ex_div) | (r_state == ST_WAIT);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: prioritised stall/flush generation, divider sequencing, PC redirect.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          DIV_LAT    = 32,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input logic        clk_i,
  input logic        rst_i,
  pipe_ctrl_if.slave bus
);

  logic        w_load_use;
  logic        w_id_hazard;
  logic        w_div_stall;
  logic        w_div_start;
  logic        w_div_busy;
  logic        w_div_done;
  logic        w_exmem_advance;
  logic [4:0]  w_stall;
  logic [4:0]  w_flush;
  logic        w_pc_valid;
  logic [31:0] w_pc;

  assign w_load_use  = bus.ex_rmem_i & (bus.ex_waddr_i != 5'd0) &
                       ((bus.ex_waddr_i == bus.id_rs_i) | (bus.ex_waddr_i == bus.id_rt_i));
  assign w_id_hazard = bus.id_branch_stall_i | w_load_use;

  // each source holds every register upstream of its bubble point
  always_comb begin
    w_stall    = '0;
    w_flush    = '0;
    w_pc_valid = 1'b0;
    w_pc       = '0;
    if (rst_i) begin
      w_flush       = '1;
      w_flush[PC_B] = 1'b0;
    end else if (bus.exc_valid_i) begin
      w_flush       = '1;
      w_flush[PC_B] = 1'b0;
      w_pc_valid    = 1'b1;
      w_pc          = bus.exc_is_eret_i ? bus.epc_i : EXC_VECTOR;
    end else if (bus.mem_busy_i) begin
      w_stall          = 5'b01111;
      w_flush[MEMWB_B] = 1'b1;
    end else if (w_div_stall) begin
      w_stall          = 5'b00111;
      w_flush[EXMEM_B] = 1'b1;
    end else if (w_id_hazard) begin
      w_stall         = 5'b00011;
      w_flush[IDEX_B] = 1'b1;
    end else if (bus.if_busy_i) begin
      w_stall         = 5'b00001;
      w_flush[IFID_B] = 1'b1;
    end
  end

  assign w_exmem_advance = ~w_stall[EXMEM_B];

  div_seq #(.DIV_LAT(DIV_LAT)) u_div_seq (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .i_ex_div        (bus.ex_div_i),
    .i_mem_busy      (bus.mem_busy_i),
    .i_exc_valid     (bus.exc_valid_i),
    .i_exmem_advance (w_exmem_advance),
    .o_div_start     (w_div_start),
    .o_div_busy      (w_div_busy),
    .o_div_done      (w_div_done),
    .o_div_stall     (w_div_stall)
  );

  assign bus.stall_o        = w_stall;
  assign bus.flush_o        = w_flush;
  assign bus.new_pc_valid_o = w_pc_valid;
  assign bus.new_pc_o       = w_pc;
  assign bus.div_start_o    = w_div_start & ~rst_i;
  assign bus.div_busy_o     = w_div_busy;
  assign bus.div_done_o     = w_div_done;

endmodule
